// File: rtl/sys_bus_ctrl.sv
// System-bus controller: decodes the LSU address into a peripheral slot, issues a
// one-cycle slot request, waits for ready or timeout and returns a registered response.
module sys_bus_ctrl #(
    parameter int                 N_SLOTS   = 8,
    parameter logic [N_SLOTS-1:0] SLOT_MASK = 8'b1000_1001,
    parameter int                 TIMEOUT   = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 m_req_i,
    input  logic                 m_we_i,
    input  logic [3:0]           m_be_i,
    input  logic [31:0]          m_addr_i,
    input  logic [31:0]          m_wd_i,
    output logic [31:0]          m_rd_o,
    output logic                 m_ready_o,
    output logic [N_SLOTS-1:0]   s_req_o,
    output logic                 s_we_o,
    output logic [3:0]           s_be_o,
    output logic [31:0]          s_addr_o,
    output logic [31:0]          s_wd_o,
    input  logic [N_SLOTS*32-1:0] s_rd_i,
    input  logic [N_SLOTS-1:0]   s_ready_i,
    output logic                 err_o,
    output logic [31:0]          err_addr_o
);

    localparam int              CW       = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0]   CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t               state_q;
    logic [CW-1:0]        cnt_q;
    logic [N_SLOTS-1:0]   sel_oh_q;
    logic                 we_q;
    logic [3:0]           be_q;
    logic [31:0]          addr_q;
    logic [31:0]          wd_q;
    logic [N_SLOTS-1:0]   s_req_q;
    logic                 m_ready_q;
    logic [31:0]          m_rd_q;
    logic                 err_q;
    logic [31:0]          err_addr_q;

    logic [N_SLOTS-1:0]   dec_oh_d;
    logic                 mapped_d;
    logic                 ready_sel_d;
    logic [31:0]          rd_sel_d;

    // Slots at or beyond N_SLOTS decode to all-zero and therefore read as unmapped.
    always_comb begin
        dec_oh_d = '0;
        rd_sel_d = '0;
        for (int k = 0; k < N_SLOTS; k++) begin
            dec_oh_d[k] = (m_addr_i[31:24] == 8'(k));
            if (sel_oh_q[k]) rd_sel_d = s_rd_i[32*k +: 32];
        end
    end

    assign mapped_d    = |(dec_oh_d & SLOT_MASK);
    assign ready_sel_d = |(s_ready_i & sel_oh_q);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sel_oh_q   <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wd_q       <= '0;
            s_req_q    <= '0;
            m_ready_q  <= 1'b0;
            m_rd_q     <= '0;
            err_q      <= 1'b0;
            err_addr_q <= '0;
        end else begin
            // NOTE: pulse outputs default low here, so any assignment below lasts one cycle.
            s_req_q   <= '0;
            m_ready_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m_req_i) begin
                        we_q     <= m_we_i;
                        be_q     <= m_be_i;
                        addr_q   <= m_addr_i;
                        wd_q     <= m_wd_i;
                        sel_oh_q <= dec_oh_d & SLOT_MASK;
                        if (mapped_d) begin
                            state_q <= ISSUE;
                            s_req_q <= dec_oh_d;
                        end else begin
                            state_q    <= DONE;
                            m_ready_q  <= 1'b1;
                            m_rd_q     <= '0;
                            err_q      <= 1'b1;
                            err_addr_q <= m_addr_i;
                        end
                    end
                end
                ISSUE, WAIT: begin
                    // Ready is tested before the timeout so a last-cycle ready still returns data.
                    if (ready_sel_d) begin
                        state_q   <= DONE;
                        m_ready_q <= 1'b1;
                        m_rd_q    <= we_q ? 32'd0 : rd_sel_d;
                    end else if (state_q == WAIT && cnt_q == CNT_LAST) begin
                        state_q    <= DONE;
                        m_ready_q  <= 1'b1;
                        m_rd_q     <= '0;
                        err_q      <= 1'b1;
                        err_addr_q <= addr_q;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= (state_q == ISSUE) ? '0 : cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    m_rd_q  <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m_ready_o  = m_ready_q;
    assign m_rd_o     = m_rd_q;
    assign err_o      = err_q;
    assign err_addr_o = err_addr_q;
    assign s_req_o    = s_req_q;
    assign s_we_o     = we_q;
    assign s_be_o     = be_q;
    assign s_addr_o   = {8'd0, addr_q[23:0]};
    assign s_wd_o     = wd_q;

endmodule
